// File: rtl/seg_bcd_encoder_if.sv
// ----------------------------------------------------------------------------
// seg_bcd_encoder_if
//
// Purpose: request/result bundle between a producer of binary display values
// and the seg_bcd_encoder block.
//
// Signals:
//   valid_i  producer -> encoder  request to convert bin_i / dp_i
//   ready_o  encoder -> producer  encoder idle, request will be taken
//   bin_i    producer -> encoder  unsigned value to display (BIN_W bits)
//   dp_i     producer -> encoder  decimal-point enables, bit i = digit i
//   done_o   encoder -> producer  one-cycle pulse, data_o just updated
//   data_o   encoder -> producer  segment bytes {dp,g,f,e,d,c,b,a},
//                                 active-low, index 0 = rightmost digit
//
// Modports: master = side issuing requests, slave = the encoder.
// ----------------------------------------------------------------------------
interface seg_bcd_encoder_if #(
   parameter int DIGITS = 8,
   parameter int BIN_W  = 27
);
   logic              valid_i;
   logic              ready_o;
   logic [BIN_W-1:0]  bin_i;
   logic [DIGITS-1:0] dp_i;
   logic              done_o;
   logic [7:0]        data_o [0:DIGITS-1];

   modport master (
      output valid_i, bin_i, dp_i,
      input  ready_o, done_o, data_o
   );

   modport slave (
      input  valid_i, bin_i, dp_i,
      output ready_o, done_o, data_o
   );
endinterface

// File: rtl/seg_bcd_encoder.sv
// ----------------------------------------------------------------------------
// seg_bcd_encoder
//
// Purpose: converts an unsigned binary value into DIGITS active-low
// 7-segment bytes for tdm_mux. A sequential shift-and-add-3 conversion runs
// for BIN_W cycles, then one encode cycle applies leading-zero blanking,
// decimal points and overflow dashes. Results stay registered until the
// next conversion finishes.
//
// Ports:
//   clk_i   system clock, rising edge
//   rstn_i  asynchronous active-low reset
//   bus     seg_bcd_encoder_if.slave (valid/ready request, bin/dp inputs,
//           done pulse and registered data_o array)
// ----------------------------------------------------------------------------
module seg_bcd_encoder #(
   parameter int DIGITS = 8,
   parameter int BIN_W  = 27
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   seg_bcd_encoder_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_ENCODE = 2'd2;

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
   function automatic longint unsigned max_value();
      longint unsigned p;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

   localparam longint unsigned MAX_VAL = max_value();

   // Active-low segments g..a for one decimal digit.
   function automatic logic [6:0] digit_segs(input logic [3:0] d);
      case (d)
         4'd0:    digit_segs = 7'h40;
         4'd1:    digit_segs = 7'h79;
         4'd2:    digit_segs = 7'h24;
         4'd3:    digit_segs = 7'h30;
         4'd4:    digit_segs = 7'h19;
         4'd5:    digit_segs = 7'h12;
         4'd6:    digit_segs = 7'h02;
         4'd7:    digit_segs = 7'h78;
         4'd8:    digit_segs = 7'h00;
         4'd9:    digit_segs = 7'h10;
         default: digit_segs = 7'h7F;
      endcase
   endfunction

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [BIN_W-1:0]  bin_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  bcd_adj;
   logic [DIGITS-1:0] dp_q;
   logic              ovf_q;
   logic [DIGITS-1:0] blank;
   logic              lead;
   logic [7:0]        seg_next [0:DIGITS-1];

   assign bus.ready_o = (state == ST_IDLE);

   // Add-3 correction: any BCD nibble of 5 or more is bumped before the
   // shift so that doubling carries correctly into the next decade.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Segment encoding of the finished BCD value. A digit above position 0
   // is blanked while every nibble and dp bit from it upward is zero, so
   // an enabled decimal point keeps its digit (and everything below) lit.
   always_comb begin
      lead  = 1'b1;
      blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lead     = lead & (bcd_q[4*i +: 4] == 4'd0) & ~dp_q[i];
         blank[i] = lead;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf_q) begin
            seg_next[i] = 8'hBF;
         end else if (blank[i]) begin
            seg_next[i] = 8'hFF;
         end else begin
            seg_next[i] = {~dp_q[i], digit_segs(bcd_q[4*i +: 4])};
         end
      end
   end

   // Control FSM and datapath. Overflowed values still shift for the full
   // count so the latency never depends on the input value.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bin_q       <= '0;
         bcd_q       <= '0;
         dp_q        <= '0;
         ovf_q       <= 1'b0;
         bus.done_o  <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            bus.data_o[i] <= 8'hFF;
         end
      end else begin
         bus.done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.valid_i) begin
                  bin_q <= bus.bin_i;
                  dp_q  <= bus.dp_i;
                  ovf_q <= (64'(bus.bin_i) > MAX_VAL);
                  bcd_q <= '0;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
               bin_q <= {bin_q[BIN_W-2:0], 1'b0};
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  state <= ST_ENCODE;
               end
            end
            ST_ENCODE: begin
               for (int i = 0; i < DIGITS; i++) begin
                  bus.data_o[i] <= seg_next[i];
               end
               bus.done_o <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_bcd_encoder.sv
// ----------------------------------------------------------------------------
// tb_seg_bcd_encoder
//
// Purpose: self-checking bench for seg_bcd_encoder. A decimal-arithmetic
// model predicts ready/done/data every cycle; directed cases pin literal
// display patterns, latency, reset and busy behaviour; a random phase
// drives arbitrary request traffic.
// ----------------------------------------------------------------------------
module tb_seg_bcd_encoder;

   localparam int DIGITS = 8;
   localparam int BIN_W  = 27;

   typedef logic [7:0] byte_arr_t [0:DIGITS-1];

   logic clk_i = 1'b0;
   logic rstn_i;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   seg_bcd_encoder_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   seg_bcd_encoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .bus    (bus.slave)
   );

   // Segment byte for one decimal digit, dp off.
   function automatic logic [7:0] digitByte(input int d);
      case (d)
         0:       return 8'hC0;
         1:       return 8'hF9;
         2:       return 8'hA4;
         3:       return 8'hB0;
         4:       return 8'h99;
         5:       return 8'h92;
         6:       return 8'h82;
         7:       return 8'hF8;
         8:       return 8'h80;
         default: return 8'h90;
      endcase
   endfunction

   // Display pattern computed from the decimal value: split into digits by
   // division, find the highest digit that is nonzero or carries a dp, and
   // blank everything above it.
   function automatic void expPattern(input longint unsigned val,
                                      input logic [DIGITS-1:0] dp,
                                      output byte_arr_t pat);
      longint unsigned limit;
      longint unsigned v;
      int d [DIGITS];
      int topIdx;
      limit = 1;
      for (int i = 0; i < DIGITS; i++) limit = limit * 10;
      if (val >= limit) begin
         for (int i = 0; i < DIGITS; i++) pat[i] = 8'hBF;
         return;
      end
      v = val;
      for (int i = 0; i < DIGITS; i++) begin
         d[i] = int'(v % 10);
         v    = v / 10;
      end
      topIdx = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (d[i] != 0 || dp[i]) topIdx = i;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (i > topIdx) begin
            pat[i] = 8'hFF;
         end else begin
            pat[i] = digitByte(d[i]);
            if (dp[i]) pat[i][7] = 1'b0;
         end
      end
   endfunction

   function automatic logic [8*DIGITS-1:0] packBytes(input byte_arr_t a);
      logic [8*DIGITS-1:0] r;
      for (int i = 0; i < DIGITS; i++) r[8*i +: 8] = a[i];
      return r;
   endfunction

   function automatic logic [BIN_W-1:0] randValue();
      case ($urandom_range(0, 3))
         0:       return BIN_W'($urandom_range(0, 999));
         1:       return BIN_W'($urandom_range(0, 99999999));
         2:       return BIN_W'($urandom_range(99999990, 100000010));
         default: return BIN_W'($urandom);
      endcase
   endfunction

   // Reference model: countdown from acceptance to the result edge.
   byte_arr_t expData;
   byte_arr_t pendData;
   logic      expDone;
   int        busyCnt;

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         busyCnt = 0;
         expDone = 1'b0;
         for (int i = 0; i < DIGITS; i++) expData[i] = 8'hFF;
      end else begin
         expDone = 1'b0;
         if (busyCnt > 0) begin
            busyCnt = busyCnt - 1;
            if (busyCnt == 0) begin
               expData = pendData;
               expDone = 1'b1;
            end
         end else if (bus.valid_i) begin
            expPattern(64'(bus.bin_i), bus.dp_i, pendData);
            busyCnt = BIN_W + 1;
         end
      end
   end

   // Cycle-by-cycle comparison of all DUT outputs against the model.
   int negCyc      = 0;
   int doneCount   = 0;
   int lastDoneCyc = 0;
   int lastGap     = 0;

   always @(negedge clk_i) begin
      negCyc = negCyc + 1;
      tests  = tests + 1;
      if (bus.ready_o !== (busyCnt == 0)) begin
         fails = fails + 1;
         $display("[TB] FAIL ready cyc %0d: got %b, expected %b", negCyc, bus.ready_o, busyCnt == 0);
      end
      tests = tests + 1;
      if (bus.done_o !== expDone) begin
         fails = fails + 1;
         $display("[TB] FAIL done cyc %0d: got %b, expected %b", negCyc, bus.done_o, expDone);
      end
      tests = tests + 1;
      if (packBytes(bus.data_o) !== packBytes(expData)) begin
         fails = fails + 1;
         $display("[TB] FAIL data cyc %0d: got %h, expected %h", negCyc, packBytes(bus.data_o), packBytes(expData));
      end
      if (bus.done_o === 1'b1) begin
         doneCount   = doneCount + 1;
         lastGap     = negCyc - lastDoneCyc;
         lastDoneCyc = negCyc;
      end
   end

   task automatic checkValue(input string name, input int got, input int exp);
      tests = tests + 1;
      if (got != exp) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic checkBytes(input string name, input byte_arr_t got, input byte_arr_t exp);
      tests = tests + 1;
      if (packBytes(got) !== packBytes(exp)) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %h, expected %h", name, packBytes(got), packBytes(exp));
      end
   endtask

   task automatic checkOutput(input string name, input byte_arr_t exp);
      checkBytes(name, bus.data_o, exp);
   endtask

   // Issue one request, scramble inputs after acceptance, and measure the
   // number of edges from acceptance until done_o is seen.
   task automatic applyStimulus(input logic [BIN_W-1:0] val,
                                input logic [DIGITS-1:0] dp,
                                output int latency);
      int guard;
      guard = 0;
      @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.bin_i   = val;
      bus.dp_i    = dp;
      while (bus.ready_o !== 1'b1 && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard >= 100) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("[TB] FAIL accept timeout: got ready %b, expected 1", bus.ready_o);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      bus.valid_i = 1'b0;
      bus.bin_i   = BIN_W'($urandom);
      bus.dp_i    = DIGITS'($urandom);
      latency = 0;
      while (bus.done_o !== 1'b1 && latency < 60) begin
         @(negedge clk_i);
         latency++;
      end
   endtask

   byte_arr_t e;
   byte_arr_t p;
   int        lat;
   int        startDone;
   int        guard;

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstn_i      = 1'b0;
      bus.valid_i = 1'b0;
      bus.bin_i   = '0;
      bus.dp_i    = '0;

      // Pin the model against hand-computed patterns.
      expPattern(64'd12345678, 8'h00, p);
      e = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
      checkBytes("model 12345678", p, e);
      expPattern(64'd5, 8'b0000_0100, p);
      e = '{8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkBytes("model dp", p, e);
      expPattern(64'd100000000, 8'hFF, p);
      e = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
      checkBytes("model ovf", p, e);

      repeat (3) @(negedge clk_i);
      e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkOutput("reset data", e);
      checkValue("reset ready", int'(bus.ready_o), 1);
      checkValue("reset done", int'(bus.done_o), 0);
      rstn_i = 1'b1;

      applyStimulus(27'd0, 8'h00, lat);
      checkValue("zero latency", lat, 28);
      e = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkOutput("zero", e);

      applyStimulus(27'd12345678, 8'h00, lat);
      checkValue("full latency", lat, 28);
      e = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
      checkOutput("full digits", e);

      applyStimulus(27'd99999999, 8'h00, lat);
      e = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
      checkOutput("max in range", e);

      applyStimulus(27'd100000000, 8'hFF, lat);
      e = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
      checkOutput("first overflow", e);
      checkValue("ovf latency", lat, 28);

      applyStimulus(27'h7FF_FFFF, 8'h00, lat);
      checkOutput("all ones", e);

      applyStimulus(27'd5, 8'b0000_0100, lat);
      e = '{8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkOutput("decimal point", e);

      // Reset in the middle of a conversion.
      @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.bin_i   = 27'd12345678;
      bus.dp_i    = 8'h00;
      @(posedge clk_i);
      @(negedge clk_i);
      bus.valid_i = 1'b0;
      repeat (10) @(negedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkOutput("async reset data", e);
      checkValue("async reset ready", int'(bus.ready_o), 1);
      checkValue("async reset done", int'(bus.done_o), 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      applyStimulus(27'd9, 8'h00, lat);
      checkValue("post-reset latency", lat, 28);
      e = '{8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkOutput("post-reset", e);

      // A request pulsed while busy must be dropped.
      @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.bin_i   = 27'd7;
      bus.dp_i    = 8'h00;
      @(posedge clk_i);
      @(negedge clk_i);
      bus.valid_i = 1'b0;
      startDone   = doneCount;
      repeat (5) @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.bin_i   = 27'd42;
      @(negedge clk_i);
      bus.valid_i = 1'b0;
      repeat (40) @(negedge clk_i);
      checkValue("busy done count", doneCount - startDone, 1);
      e = '{8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      checkOutput("busy ignored", e);

      // Held valid: consecutive results spaced by the full turnaround.
      @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.bin_i   = 27'd3;
      startDone   = doneCount;
      guard       = 0;
      while (doneCount - startDone < 2 && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      checkValue("held done pulses", doneCount - startDone, 2);
      checkValue("held gap", lastGap, 29);
      bus.valid_i = 1'b0;
      repeat (40) @(negedge clk_i);

      // Random traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk_i);
         bus.valid_i = ($urandom_range(0, 9) < 3);
         bus.bin_i   = randValue();
         bus.dp_i    = ($urandom_range(0, 1) == 0) ? 8'h00 : DIGITS'($urandom);
      end
      @(negedge clk_i);
      bus.valid_i = 1'b0;
      repeat (40) @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
